hit_scorer: RTL and testbench

HIT_SCORER -- requirements
Module: hit_scorer

---
 rtl/hit_scorer_pkg.sv | 35 +++
 rtl/seg7_decoder.sv | 34 +++
 rtl/hit_scorer.sv | 213 +++++++++++++++++++++
 tb/tb_hit_scorer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_scorer_pkg.sv
// ============================================================================
// Module : hit_scorer_pkg
// Brief  : Shared FSM state type, photo array size and seven-segment patterns
//          for the laser hit scorer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hit_scorer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam int         NUM_PHOTO = 10;
    localparam logic [3:0] NO_TARGET = 4'hF;

    // Active-low segment patterns, bit6 = g ... bit0 = a
    localparam logic [6:0] c_seg_0     = 7'b1000000;
    localparam logic [6:0] c_seg_1     = 7'b1111001;
    localparam logic [6:0] c_seg_2     = 7'b0100100;
    localparam logic [6:0] c_seg_3     = 7'b0110000;
    localparam logic [6:0] c_seg_4     = 7'b0011001;
    localparam logic [6:0] c_seg_5     = 7'b0010010;
    localparam logic [6:0] c_seg_6     = 7'b0000010;
    localparam logic [6:0] c_seg_7     = 7'b1111000;
    localparam logic [6:0] c_seg_8     = 7'b0000000;
    localparam logic [6:0] c_seg_9     = 7'b0010000;
    localparam logic [6:0] c_seg_blank = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module : seg7_decoder
// Brief  : One BCD digit to an active-low seven-segment pattern.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg7_decoder
    import hit_scorer_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_seg_blank;
        case (i_bcd)
            4'd0:    o_seg = c_seg_0;
            4'd1:    o_seg = c_seg_1;
            4'd2:    o_seg = c_seg_2;
            4'd3:    o_seg = c_seg_3;
            4'd4:    o_seg = c_seg_4;
            4'd5:    o_seg = c_seg_5;
            4'd6:    o_seg = c_seg_6;
            4'd7:    o_seg = c_seg_7;
            4'd8:    o_seg = c_seg_8;
            4'd9:    o_seg = c_seg_9;
            default: o_seg = c_seg_blank;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hit_scorer.sv
// ============================================================================
// Module : hit_scorer
// Brief  : Debounces a photodiode array, counts laser hits on the lit targets
//          with a cooldown window and shows a 4-digit BCD score.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hit_scorer
    import hit_scorer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 25000000
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PHOTO-1:0] photo_array,
    input  logic [3:0]           target_a,
    input  logic [3:0]           target_b,
    input  logic                 laser_active,
    input  logic                 game_enable,
    input  logic                 score_clear,
    output logic                 hit_pulse,
    output logic [3:0]           hit_index,
    output logic [6:0]           score_digit_a,
    output logic [6:0]           score_digit_b,
    output logic [6:0]           score_digit_c,
    output logic [6:0]           score_digit_d
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [DB_W-1:0] c_db_last = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] c_cd_last = CD_W'(COOLDOWN_CYCLES - 1);

    logic [NUM_PHOTO-1:0] r_sync1;
    logic [NUM_PHOTO-1:0] r_sync2;
    logic [NUM_PHOTO-1:0] r_deb;
    logic [NUM_PHOTO-1:0] r_deb_d;
    logic [DB_W-1:0]      r_db_cnt [NUM_PHOTO];

    logic [NUM_PHOTO-1:0] w_rise;
    logic [NUM_PHOTO-1:0] w_target;
    logic [NUM_PHOTO-1:0] w_qual;
    logic [3:0]           w_first;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_hit;
    logic [CD_W-1:0]      r_cd_cnt;

    logic                 r_hit_pulse;
    logic [3:0]           r_hit_index;
    logic [3:0][3:0]      r_score;
    logic [3:0][3:0]      w_score_inc;
    logic                 w_score_sat;
    logic [3:0][6:0]      w_seg;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= photo_array;
            r_sync2 <= r_sync1;
        end
    end

    // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clock) begin
        if (reset) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < NUM_PHOTO; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_deb_d <= r_deb;
            for (int i = 0; i < NUM_PHOTO; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_db_last) begin
                    r_deb[i]    <= ~r_deb[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Target codes 10-15 never match a bit index, so they select nothing
    always_comb begin
        w_rise  = r_deb & ~r_deb_d;
        w_target = '0;
        for (int i = 0; i < NUM_PHOTO; i++) begin
            w_target[i] = (target_a == 4'(i)) || (target_b == 4'(i));
        end
        w_qual  = w_rise & w_target & {NUM_PHOTO{laser_active}};
        w_first = NO_TARGET;
        for (int i = NUM_PHOTO - 1; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_first = 4'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A clear in the same cycle discards the hit entirely, including the move to cooldown
    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        if (!game_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_PLAY;
                end
                ST_PLAY: begin
                    if (|w_qual && !score_clear) begin
                        w_hit       = 1'b1;
                        w_state_nxt = ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    if (r_cd_cnt == c_cd_last) begin
                        w_state_nxt = ST_PLAY;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cd_cnt <= '0;
        end else if (w_hit) begin
            r_cd_cnt <= '0;
        end else if (r_state == ST_COOLDOWN) begin
            r_cd_cnt <= r_cd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_pulse <= 1'b0;
            r_hit_index <= 4'd0;
        end else begin
            r_hit_pulse <= w_hit;
            if (w_hit) begin
                r_hit_index <= w_first;
            end
        end
    end

    // Decimal ripple: a digit at 9 wraps to 0 and passes the carry up
    always_comb begin
        logic carry;
        w_score_inc = r_score;
        w_score_sat = 1'b1;
        carry       = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (r_score[d] != 4'd9) begin
                w_score_sat = 1'b0;
            end
            if (carry) begin
                if (r_score[d] == 4'd9) begin
                    w_score_inc[d] = 4'd0;
                end else begin
                    w_score_inc[d] = r_score[d] + 4'd1;
                    carry          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || score_clear) begin
            r_score <= '0;
        end else if (w_hit && !w_score_sat) begin
            r_score <= w_score_inc;
        end
    end

    for (genvar gd = 0; gd < 4; gd++) begin : g_digit
        seg7_decoder u_seg7_decoder (
            .i_bcd (r_score[gd]),
            .o_seg (w_seg[gd])
        );
    end

    assign hit_pulse     = r_hit_pulse;
    assign hit_index     = r_hit_index;
    assign score_digit_a = w_seg[0];
    assign score_digit_b = w_seg[1];
    assign score_digit_c = w_seg[2];
    assign score_digit_d = w_seg[3];

endmodule

`default_nettype wire

// File: tb/tb_hit_scorer.sv
// ============================================================================
// Module : tb_hit_scorer
// Brief  : Self-checking bench for hit_scorer: vector table, directed corner
//          sequences and random traffic against an integer reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hit_scorer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] photo_m;
    logic [9:0] photo_f;
    logic [3:0] ta;
    logic [3:0] tb;
    logic       laser;
    logic       en;
    logic       clr;

    logic       pulse_m, pulse_f;
    logic [3:0] idx_m, idx_f;
    logic [6:0] da_m, db_m, dc_m, dd_m;
    logic [6:0] da_f, db_f, dc_f, dd_f;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;
    bit ftog    = 1'b0;

    always #5 clk = ~clk;

    hit_scorer #(.DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(8)) dut (
        .clock(clk), .reset(rst), .photo_array(photo_m), .target_a(ta), .target_b(tb),
        .laser_active(laser), .game_enable(en), .score_clear(clr),
        .hit_pulse(pulse_m), .hit_index(idx_m),
        .score_digit_a(da_m), .score_digit_b(db_m), .score_digit_c(dc_m), .score_digit_d(dd_m)
    );

    // Fast instance so thousands of hits fit in a short run
    hit_scorer #(.DEBOUNCE_CYCLES(1), .COOLDOWN_CYCLES(1)) dut_fast (
        .clock(clk), .reset(rst), .photo_array(photo_f), .target_a(ta), .target_b(tb),
        .laser_active(laser), .game_enable(en), .score_clear(clr),
        .hit_pulse(pulse_f), .hit_index(idx_f),
        .score_digit_a(da_f), .score_digit_b(db_f), .score_digit_c(dc_f), .score_digit_d(dd_f)
    );

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] digs(int s);
        return {seg_of((s / 1000) % 10), seg_of((s / 100) % 10), seg_of((s / 10) % 10), seg_of(s % 10)};
    endfunction

    function automatic logic [63:0] obs(logic p, logic [3:0] i, logic [27:0] d);
        return {31'd0, p, i, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // ---------------- reference model (integer score, per-instance arrays) ----------------
    int         m_dbn [2];
    int         m_cdn [2];
    logic [9:0] m_s1 [2];
    logic [9:0] m_s2 [2];
    logic [9:0] m_deb [2];
    logic [9:0] m_prev [2];
    int         m_cnt [2][10];
    int         m_state [2];
    int         m_cd [2];
    int         m_score [2];
    logic       m_pulse [2];
    logic [3:0] m_idx [2];

    initial begin
        m_dbn[0] = 4; m_cdn[0] = 8;
        m_dbn[1] = 1; m_cdn[1] = 1;
    end

    task automatic model_step(input int k, input logic [9:0] ph);
        int low;
        int ns;
        bit hit;
        if (rst) begin
            m_s1[k] = '0; m_s2[k] = '0; m_deb[k] = '0; m_prev[k] = '0;
            for (int i = 0; i < 10; i++) m_cnt[k][i] = 0;
            m_state[k] = 0; m_cd[k] = 0; m_score[k] = 0; m_pulse[k] = 1'b0; m_idx[k] = 4'd0;
            return;
        end
        low = -1;
        for (int i = 0; i < 10; i++) begin
            if (low < 0 && m_deb[k][i] && !m_prev[k][i] && laser &&
                (int'(ta) == i || int'(tb) == i)) low = i;
        end
        hit = (m_state[k] == 1) && en && (low >= 0) && !clr;
        m_pulse[k] = hit;
        if (hit) m_idx[k] = 4'(low);
        if (clr) m_score[k] = 0;
        else if (hit && m_score[k] < 9999) m_score[k] = m_score[k] + 1;
        if (!en) ns = 0;
        else if (m_state[k] == 0) ns = 1;
        else if (m_state[k] == 1) ns = hit ? 2 : 1;
        else ns = (m_cd[k] == m_cdn[k] - 1) ? 1 : 2;
        if (hit) m_cd[k] = 0;
        else if (m_state[k] == 2) m_cd[k] = m_cd[k] + 1;
        m_state[k] = ns;
        m_prev[k] = m_deb[k];
        for (int i = 0; i < 10; i++) begin
            if (m_s2[k][i] == m_deb[k][i]) m_cnt[k][i] = 0;
            else begin
                m_cnt[k][i] = m_cnt[k][i] + 1;
                if (m_cnt[k][i] == m_dbn[k]) begin
                    m_deb[k][i] = ~m_deb[k][i];
                    m_cnt[k][i] = 0;
                end
            end
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = ph;
    endtask

    always @(posedge clk) begin
        model_step(0, photo_m);
        model_step(1, photo_f);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_main", obs(pulse_m, idx_m, {dd_m, dc_m, db_m, da_m}),
                  obs(m_pulse[0], m_idx[0], digs(m_score[0])));
            check("model_fast", obs(pulse_f, idx_f, {dd_f, dc_f, db_f, da_f}),
                  obs(m_pulse[1], m_idx[1], digs(m_score[1])));
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [9:0] photo;
        logic [3:0] ta;
        logic [3:0] tb;
        logic       laser;
        logic       exp_hit;
        logic [3:0] exp_idx;
        int         exp_score;
    } vec_t;

    vec_t vecs [8];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fast_tick();
        @(negedge clk);
        ftog    = ~ftog;
        photo_f = {8'b0, ~ftog, ftog};
    endtask

    function automatic logic [27:0] main_digs();
        return {dd_m, dc_m, db_m, da_m};
    endfunction

    function automatic logic [27:0] fast_digs();
        return {dd_f, dc_f, db_f, da_f};
    endfunction

    initial begin
        int  pulses;
        bit  found;

        vecs[0] = '{10'b0000001000, 4'd3,  4'd15, 1'b1, 1'b1, 4'd3, 1};
        vecs[1] = '{10'b0000001000, 4'd3,  4'd15, 1'b0, 1'b0, 4'd3, 1};
        vecs[2] = '{10'b0010000000, 4'd3,  4'd15, 1'b1, 1'b0, 4'd3, 1};
        vecs[3] = '{10'b0000100100, 4'd5,  4'd2,  1'b1, 1'b1, 4'd2, 2};
        vecs[4] = '{10'b1000000000, 4'd9,  4'd9,  1'b1, 1'b1, 4'd9, 3};
        vecs[5] = '{10'b0000010000, 4'd12, 4'd4,  1'b1, 1'b1, 4'd4, 4};
        vecs[6] = '{10'b0100000001, 4'd8,  4'd0,  1'b1, 1'b1, 4'd0, 5};
        vecs[7] = '{10'b0001000000, 4'd10, 4'd11, 1'b1, 1'b0, 4'd0, 5};

        rst = 1'b1; photo_m = '0; photo_f = '0; ta = 4'd15; tb = 4'd15;
        laser = 1'b0; en = 1'b0; clr = 1'b0;
        cyc(2);
        chk_on = 1'b1;
        check("reset_state", obs(pulse_m, idx_m, main_digs()), obs(1'b0, 4'd0, digs(0)));
        rst = 1'b0; en = 1'b1;
        cyc(2);

        for (int v = 0; v < 8; v++) begin
            ta = vecs[v].ta; tb = vecs[v].tb; laser = vecs[v].laser; photo_m = vecs[v].photo;
            cyc(7);
            check($sformatf("vec%0d", v), obs(pulse_m, idx_m, main_digs()),
                  obs(vecs[v].exp_hit, vecs[v].exp_idx, digs(vecs[v].exp_score)));
            photo_m = '0;
            cyc(20);
        end

        // Three-cycle glitch must not reach the debounced bit
        ta = 4'd3; tb = 4'd15; laser = 1'b1;
        photo_m = 10'b0000001000;
        cyc(3);
        photo_m = '0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin cyc(1); if (pulse_m) pulses++; end
        check("glitch_pulses", 64'(pulses), 64'(0));
        check("glitch_score", 64'(main_digs()), 64'(digs(5)));

        // Edge during cooldown is dropped, not queued; a later edge counts
        ta = 4'd3; tb = 4'd6;
        photo_m = 10'b0000001000;
        cyc(4);
        photo_m = 10'b0001001000;
        cyc(3);
        check("cd_first_hit", obs(pulse_m, idx_m, main_digs()), obs(1'b1, 4'd3, digs(6)));
        pulses = 0;
        for (int c = 0; c < 15; c++) begin cyc(1); if (pulse_m) pulses++; end
        check("cd_ignored", 64'(pulses), 64'(0));
        photo_m = '0;
        cyc(20);
        photo_m = 10'b0001000000;
        cyc(7);
        check("cd_later_hit", obs(pulse_m, idx_m, main_digs()), obs(1'b1, 4'd6, digs(7)));
        photo_m = '0;
        cyc(20);

        // Clear in the hit cycle wins
        ta = 4'd3; tb = 4'd15;
        photo_m = 10'b0000001000;
        cyc(6);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("clear_wins", obs(pulse_m, idx_m, main_digs()), obs(1'b0, 4'd6, digs(0)));
        pulses = 0;
        for (int c = 0; c < 10; c++) begin cyc(1); if (pulse_m) pulses++; end
        check("clear_no_late_hit", 64'(pulses), 64'(0));
        photo_m = '0;
        cyc(20);

        // Reset mid-cooldown, photo still lit at release
        photo_m = 10'b0000001000;
        cyc(7);
        check("pre_reset_hit", obs(pulse_m, idx_m, main_digs()), obs(1'b1, 4'd3, digs(1)));
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("reset_in_cooldown", obs(pulse_m, idx_m, main_digs()), obs(1'b0, 4'd0, digs(0)));
        cyc(7);
        check("edge_after_reset", obs(pulse_m, idx_m, main_digs()), obs(1'b1, 4'd3, digs(1)));
        photo_m = '0;
        cyc(20);

        // Random traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            int b;
            if ($urandom_range(0, 5) == 0) begin
                b = int'($urandom_range(0, 9));
                photo_m[b] = ~photo_m[b];
            end
            if ($urandom_range(0, 3) == 0) begin
                b = int'($urandom_range(0, 9));
                photo_f[b] = ~photo_f[b];
            end
            if ($urandom_range(0, 15) == 0) begin
                ta = 4'($urandom_range(0, 11));
                tb = 4'($urandom_range(0, 11));
            end
            laser = ($urandom_range(0, 7) != 0);
            en    = ($urandom_range(0, 99) != 0);
            clr   = ($urandom_range(0, 199) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            cyc(1);
        end

        // Long run on the fast instance: decimal carry and saturation
        rst = 1'b1; clr = 1'b0; en = 1'b1; laser = 1'b1; ta = 4'd0; tb = 4'd1;
        photo_m = '0; photo_f = '0;
        cyc(1);
        rst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 5000 && !found; c++) begin
            fast_tick();
            if (fast_digs() == digs(999)) found = 1'b1;
        end
        check("reach_0999", 64'(found), 64'(1));
        for (int c = 0; c < 10; c++) begin
            fast_tick();
            if (pulse_f) break;
        end
        check("carry_to_1000", 64'({pulse_f, dd_f, fast_digs()}), 64'({1'b1, 7'b1111001, digs(1000)}));
        found = 1'b0;
        for (int c = 0; c < 25000 && !found; c++) begin
            fast_tick();
            if (fast_digs() == digs(9999)) found = 1'b1;
        end
        check("reach_9999", 64'(found), 64'(1));
        pulses = 0;
        for (int c = 0; c < 20; c++) begin fast_tick(); if (pulse_f) pulses++; end
        check("sat_pulses", 64'(pulses), 64'(10));
        check("sat_hold", 64'(fast_digs()), 64'(digs(9999)));

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
